// File: rtl/button_debounce_pkg.sv
// Shared types and default timing for the push-button debouncer.
// Default periods assume a 100 MHz clock (10 ms settle, 1 s long press).
package button_pkg;

   localparam int DEF_STABLE_CYCLES = 1_000_000;
   localparam int DEF_HOLD_CYCLES   = 100_000_000;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } btn_state_t;

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
   } btn_out_t;

   // The button counts as accepted-pressed until a release has been confirmed.
   function automatic logic is_held(input btn_state_t s);
      return (s == PRESSED) || (s == RELEASE_CHK);
   endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: synchronise, debounce, emit level and press/release strobes.
// Optional long-press strobe is built when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce
   import button_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_raw,
   output logic button_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam int               CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             sync_q;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   btn_out_t         out_q, out_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (button_raw),
      .q     (sync_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   // The counter only runs in the check states and tops out at CNT_MAX, so it never wraps.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RELEASED: begin
            if (sync_q) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!sync_q) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync_q) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end
         end
         RELEASE_CHK: begin
            if (sync_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming transition and registered, so strobes last one cycle.
   always_comb begin
      out_d       = '0;
      out_d.level = is_held(state_d);
      out_d.press = (state_q == PRESS_CHK)   && (state_d == PRESSED);
      out_d.rel   = (state_q == RELEASE_CHK) && (state_d == RELEASED);
   end

   assign button_level  = out_q.level;
   assign press_pulse   = out_q.press;
   assign release_pulse = out_q.rel;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int               HOLD_W   = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   // Only a confirmed press restarts the count; a release bounce back into PRESSED keeps it.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if ((state_q == PRESS_CHK) && (state_d == PRESSED)) begin
         hold_d = '0;
      end else if (is_held(state_q) && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + 1'b1;
         long_d = (hold_d == HOLD_MAX);
      end
   end

   assign long_press = long_q;
`else
   logic unused_hold_cfg;

   assign unused_hold_cfg = ^HOLD_CYCLES;
   assign long_press      = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at STABLE_CYCLES=4, HOLD_CYCLES=10.
// Expected long_press follows BUTTON_DEBOUNCE_LONG_PRESS_EN.
module tb_button_debounce;

   localparam int STABLE = 4;
   localparam int HOLD   = 10;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam logic LP_EN = 1'b1;
`else
   localparam logic LP_EN = 1'b0;
`endif

   typedef struct {
      logic raw;
      logic level;
      logic press;
      logic rel;
      logic lp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic button_raw;
   logic button_level;
   logic press_pulse;
   logic release_pulse;
   logic long_press;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   button_debounce #(
      .STABLE_CYCLES (STABLE),
      .HOLD_CYCLES   (HOLD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .button_raw    (button_raw),
      .button_level  (button_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic lvl, input logic pr,
                        input logic rl, input logic lp);
      n_vec++;
      if ({button_level, press_pulse, release_pulse, long_press} !== {lvl, pr, rl, lp}) begin
         n_err++;
         $display("FAIL %s: level/press/release/long got %b%b%b%b expected %b%b%b%b",
                  name, button_level, press_pulse, release_pulse, long_press,
                  lvl, pr, rl, lp);
      end
   endtask

   // Raw changes 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
   task automatic step(input logic r);
      button_raw = r;
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input logic raw, input logic lvl, input logic pr,
                                input logic rl, input logic lp);
      vec_t v;
      v.raw   = raw;
      v.level = lvl;
      v.press = pr;
      v.rel   = rl;
      v.lp    = lp;
      vecs.push_back(v);
   endfunction

   function automatic void push_run(input int n, input logic raw, input logic lvl);
      for (int i = 0; i < n; i++) push(raw, lvl, 1'b0, 1'b0, 1'b0);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Clean press held 20: press strobe at edge 7, long press 10 cycles later.
      push_run(6, 1'b1, 1'b0);
      push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      push_run(9, 1'b1, 1'b1);
      push(1'b1, 1'b1, 1'b0, 1'b0, LP_EN);
      push_run(3, 1'b1, 1'b1);
      // Clean release held 10: release strobe at edge 7.
      push_run(6, 1'b0, 1'b1);
      push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      push_run(3, 1'b0, 1'b0);
      // Press bounce: 3 high cycles then low; nothing accepted.
      push_run(3, 1'b1, 1'b0);
      push_run(8, 1'b0, 1'b0);
      // Press, 2-cycle release bounce, re-press, then real release.
      push_run(6, 1'b1, 1'b0);
      push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      push_run(3, 1'b1, 1'b1);
      push_run(2, 1'b0, 1'b1);
      push_run(4, 1'b1, 1'b1);
      push(1'b1, 1'b1, 1'b0, 1'b0, LP_EN);
      push_run(6, 1'b0, 1'b1);
      push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      push_run(3, 1'b0, 1'b0);

      // Reset with raw held high: outputs 0, then a full-latency press after release.
      rst_n      = 1'b0;
      button_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("reset_hold[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         step(1'b1);
         check($sformatf("post_reset_press_edge%0d", e),
               (e >= 7), (e == 7), 1'b0, LP_EN && (e == 17));
      end
      for (int e = 1; e <= 10; e++) begin
         step(1'b0);
         check($sformatf("post_reset_release_edge%0d", e),
               (e < 7), 1'b0, (e == 7), 1'b0);
      end

      foreach (vecs[i]) begin
         step(vecs[i].raw);
         check($sformatf("vec[%0d]", i), vecs[i].level, vecs[i].press,
               vecs[i].rel, vecs[i].lp);
      end

      // Reset while PRESS_CHK has cnt=2: must abort with no pulse.
      for (int e = 1; e <= 5; e++) begin
         step(1'b1);
         check($sformatf("mid_check_edge%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_check_async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      button_raw = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step(1'b0);
         check($sformatf("after_abort_edge%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Clocked front end for a mechanical push-button: synchronises the raw pad signal, rejects bounce, and produces a clean level plus single-cycle press/release strobes.
- Sits between the board button pin and downstream toggle or on/off logic.
- Downstream logic clocks on press_pulse or uses it as an enable, never the raw pin.

Parameters:
- STABLE_CYCLES, 1000000, consecutive synchronised cycles a new level must hold before acceptance (10 ms at 100 MHz); legal range >= 2.
- HOLD_CYCLES, 100000000, cycles in PRESSED before long_press fires (used only with the optional feature); legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- button_raw  input  1  asynchronous button pin, active-high.
- button_level  output  1  debounced level; 1 while accepted pressed.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_press  output  1  one-cycle strobe after sustained hold; tied 0 when the feature is out.

Behaviour:
- Reset (rst_n=0, async): synchroniser flops=0, state=RELEASED, counters=0, all outputs 0. Deassertion is synchronous to clk; release reset on a clock edge not shared with stimulus changes.
- Synchroniser: 2 flops; sync_q is the second flop.
- FSM, all outputs registered:
  - RELEASED: if sync_q=1, go to PRESS_CHK with cnt=0.
  - PRESS_CHK: if sync_q=0, go to RELEASED with cnt=0 (bounce rejected, no pulse).
    - Else if cnt=STABLE_CYCLES-1, go to PRESSED.
    - Else cnt++.
  - PRESSED: if sync_q=0, go to RELEASE_CHK with cnt=0.
  - RELEASE_CHK: if sync_q=1, go to PRESSED (no pulse, no level change).
    - Else if cnt=STABLE_CYCLES-1, go to RELEASED.
    - Else cnt++.
- Latency: raw held stable from the edge that first samples it:
  - The new state and button_level appear after edge STABLE_CYCLES+3.
  - press_pulse / release_pulse are high for exactly that one following cycle.
- Pulse rules:
  - press_pulse and release_pulse are never high together.
  - Every press_pulse is followed by exactly one release_pulse before the next press_pulse.
- Counter:
  - Width $clog2(STABLE_CYCLES).
  - Saturates by construction and never wraps.
  - Cleared on every state change.
- Reset mid-check: the FSM aborts and no pulse is emitted.
- Raw held high through reset: after reset release it is treated as a fresh press with the full latency.

Optional Feature:
- Macro BUTTON_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - hold counter, width $clog2(HOLD_CYCLES+1), cleared on entry to PRESSED.
  - It increments each cycle in PRESSED or RELEASE_CHK and saturates at HOLD_CYCLES.
  - long_press is high for one cycle exactly HOLD_CYCLES cycles after the press_pulse cycle.
  - long_press fires at most once per press; a bounce back into PRESSED does not restart the count.
- Undefined: no hold counter is synthesised; long_press is constant 0.

Decomposition:
- Package button_pkg:
  - btn_state_t enum {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK}, 2-bit.
  - Default-period localparams.
- Sub-module sync_2ff (clk, rst_n, d, q): reset value 0, reusable for other pads.

Test Plan (STABLE_CYCLES=4, HOLD_CYCLES=10):
- Reset: rst_n=0 with button_raw=1 → all outputs 0; after release, press_pulse at edge 7.
- Clean press: raw 0→1 held 20 cycles → level rises after edge 7, press_pulse exactly 1 cycle, release_pulse 0.
- Bounce: raw 1 for 3 cycles, then 0 → no press_pulse, level stays 0.
- Release bounce: from PRESSED, raw 0 for 2 cycles then 1, later 0 held 10 → only one release_pulse, 7 edges after the final fall.
- Reset asserted in PRESS_CHK (cnt=2) → outputs stay 0, FSM returns to RELEASED immediately, no pulse.
- Long press, raw held 30 cycles:
  - Macro on: long_press single pulse 10 cycles after press_pulse.
  - Macro off: long_press stays 0.
